time_set_ctrl: RTL

TIME_SET_CTRL -- requirements
Module: time_set_ctrl

---
 rtl/time_set_ctrl_if.sv | 38 +++
 rtl/time_set_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/time_set_ctrl_if.sv
// ------------------------------------------------------------------
// time_set_ctrl_if : key, tick and time-load bundle of the set controller
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

interface time_set_ctrl_if;
  logic       key_mode;
  logic       key_inc;
  logic       tick_1hz;
  logic [3:0] cur_hour_g;
  logic [3:0] cur_hour_d;
  logic [3:0] cur_min_g;
  logic [3:0] cur_min_d;
  logic       run_en;
  logic       load_en;
  logic [3:0] set_hour_g;
  logic [3:0] set_hour_d;
  logic [3:0] set_min_g;
  logic [3:0] set_min_d;
  logic       sec_clr;
  logic [7:0] blank_mask;
  logic [1:0] mode;

  modport master (
    output key_mode, key_inc, tick_1hz, cur_hour_g, cur_hour_d, cur_min_g, cur_min_d,
    input  run_en, load_en, set_hour_g, set_hour_d, set_min_g, set_min_d, sec_clr,
           blank_mask, mode
  );

  modport slave (
    input  key_mode, key_inc, tick_1hz, cur_hour_g, cur_hour_d, cur_min_g, cur_min_d,
    output run_en, load_en, set_hour_g, set_hour_d, set_min_g, set_min_d, sec_clr,
           blank_mask, mode
  );
endinterface

`default_nettype wire

// File: rtl/time_set_ctrl.sv
// ------------------------------------------------------------------
// time_set_ctrl : two-key HH:MM set controller with debounce, blink and timeout
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module time_set_ctrl #(
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int BLINK_CYC    = 12500000,
  parameter int TIMEOUT_S    = 30
) (
  input wire             CLK_50M,
  input wire             reset,
  time_set_ctrl_if.slave bus
);
  localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
  localparam int BL_W = $clog2(BLINK_CYC + 1);
  localparam int TO_W = $clog2(TIMEOUT_S + 1);
  localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [BL_W-1:0] BL_LAST  = BL_W'(BLINK_CYC - 1);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_S);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    COMMIT   = 2'd3
  } state_t;

  // key index 0 = mode, 1 = inc
  logic [1:0]      sync1_q, sync2_q, db_q, db_d, press_q, press_d;
  logic [DB_W-1:0] db_cnt_q [2];
  logic [DB_W-1:0] db_cnt_d [2];

  state_t          state_q, state_d;
  logic [3:0]      hour_g_q, hour_d_q, min_g_q, min_d_q;
  logic [3:0]      hour_g_d, hour_d_d, min_g_d, min_d_d;
  logic [TO_W-1:0] tmo_q, tmo_d;
  logic [BL_W-1:0] blink_cnt_q, blink_cnt_d;
  logic            phase_q, phase_d, arm_q, arm_d;
  logic            run_en_q, run_en_d, load_en_q, load_en_d, sec_clr_q, sec_clr_d;
  logic [7:0]      mask_q, mask_d;
  logic [1:0]      mode_q, mode_d;

  logic            mode_ev, inc_ev, in_set, inc_held, rpt_fire, hour_ok, min_ok;

  always_comb begin
    db_d    = db_q;
    press_d = 2'b00;
    for (int i = 0; i < 2; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          db_d[i]    = sync2_q[i];
          press_d[i] = db_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    in_set   = (state_q == SET_HOUR) || (state_q == SET_MIN);
    inc_held = ~db_q[1];
    mode_ev  = press_q[0];
    rpt_fire = in_set && inc_held && arm_q && bus.tick_1hz;
    inc_ev   = (press_q[1] | rpt_fire) & ~mode_ev;
    hour_ok  = ((bus.cur_hour_g < 4'd2) && (bus.cur_hour_d <= 4'd9)) ||
               ((bus.cur_hour_g == 4'd2) && (bus.cur_hour_d <= 4'd3));
    min_ok   = (bus.cur_min_g <= 4'd5) && (bus.cur_min_d <= 4'd9);

    state_d  = state_q;
    hour_g_d = hour_g_q;
    hour_d_d = hour_d_q;
    min_g_d  = min_g_q;
    min_d_d  = min_d_q;
    tmo_d    = tmo_q;

    if (blink_cnt_q == BL_LAST) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end else begin
      blink_cnt_d = blink_cnt_q + 1'b1;
      phase_d     = phase_q;
    end

    // repeat is armed by the first tick of a hold and fires on every later one
    if (!(in_set && inc_held) || press_q[1]) begin
      arm_d = 1'b0;
    end else if (bus.tick_1hz) begin
      arm_d = 1'b1;
    end else begin
      arm_d = arm_q;
    end

    case (state_q)
      RUN: begin
        tmo_d = '0;
        if (mode_ev) begin
          hour_g_d = hour_ok ? bus.cur_hour_g : 4'd0;
          hour_d_d = hour_ok ? bus.cur_hour_d : 4'd0;
          min_g_d  = min_ok  ? bus.cur_min_g  : 4'd0;
          min_d_d  = min_ok  ? bus.cur_min_d  : 4'd0;
          state_d  = SET_HOUR;
        end
      end
      SET_HOUR, SET_MIN: begin
        if (mode_ev) begin
          tmo_d   = '0;
          state_d = (state_q == SET_HOUR) ? SET_MIN : COMMIT;
        end else if (inc_ev) begin
          tmo_d       = '0;
          phase_d     = 1'b1;
          blink_cnt_d = '0;
          if (state_q == SET_HOUR) begin
            if (hour_g_q == 4'd2 && hour_d_q >= 4'd3) begin
              hour_g_d = 4'd0;
              hour_d_d = 4'd0;
            end else if (hour_d_q >= 4'd9) begin
              hour_g_d = hour_g_q + 4'd1;
              hour_d_d = 4'd0;
            end else begin
              hour_d_d = hour_d_q + 4'd1;
            end
          end else begin
            if (min_d_q >= 4'd9) begin
              min_d_d = 4'd0;
              min_g_d = (min_g_q >= 4'd5) ? 4'd0 : min_g_q + 4'd1;
            end else begin
              min_d_d = min_d_q + 4'd1;
            end
          end
        end else if (bus.tick_1hz) begin
          tmo_d = tmo_q + 1'b1;
          if (tmo_d >= TO_LIMIT) begin
            state_d = RUN;
          end
        end
      end
      default: begin
        tmo_d   = '0;
        state_d = RUN;
      end
    endcase

    run_en_d  = (state_d == RUN);
    load_en_d = (state_d == COMMIT);
    sec_clr_d = (state_d == COMMIT);
    mode_d    = state_d;
    mask_d    = 8'h00;
    if (!phase_d && state_d == SET_HOUR) mask_d = 8'h03;
    if (!phase_d && state_d == SET_MIN)  mask_d = 8'h18;
  end

  always_ff @(posedge CLK_50M or negedge reset) begin
    if (!reset) begin
      sync1_q     <= 2'b11;
      sync2_q     <= 2'b11;
      db_q        <= 2'b11;
      press_q     <= 2'b00;
      db_cnt_q[0] <= '0;
      db_cnt_q[1] <= '0;
      state_q     <= RUN;
      hour_g_q    <= 4'd0;
      hour_d_q    <= 4'd0;
      min_g_q     <= 4'd0;
      min_d_q     <= 4'd0;
      tmo_q       <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
      arm_q       <= 1'b0;
      run_en_q    <= 1'b1;
      load_en_q   <= 1'b0;
      sec_clr_q   <= 1'b0;
      mask_q      <= 8'h00;
      mode_q      <= 2'd0;
    end else begin
      sync1_q     <= {bus.key_inc, bus.key_mode};
      sync2_q     <= sync1_q;
      db_q        <= db_d;
      press_q     <= press_d;
      db_cnt_q[0] <= db_cnt_d[0];
      db_cnt_q[1] <= db_cnt_d[1];
      state_q     <= state_d;
      hour_g_q    <= hour_g_d;
      hour_d_q    <= hour_d_d;
      min_g_q     <= min_g_d;
      min_d_q     <= min_d_d;
      tmo_q       <= tmo_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      arm_q       <= arm_d;
      run_en_q    <= run_en_d;
      load_en_q   <= load_en_d;
      sec_clr_q   <= sec_clr_d;
      mask_q      <= mask_d;
      mode_q      <= mode_d;
    end
  end

  assign bus.run_en     = run_en_q;
  assign bus.load_en    = load_en_q;
  assign bus.sec_clr    = sec_clr_q;
  assign bus.blank_mask = mask_q;
  assign bus.mode       = mode_q;
  assign bus.set_hour_g = hour_g_q;
  assign bus.set_hour_d = hour_d_q;
  assign bus.set_min_g  = min_g_q;
  assign bus.set_min_d  = min_d_q;
endmodule

`default_nettype wire
